// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: parity mode codes, transmitter FSM state codes and helpers.
// Intended to be reused by the matching receiver.
package uart_tx_fifo_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_EVEN  = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;
    localparam logic [2:0] PAR_BAD   = 3'd7;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Maps a parity mode name to its code; unknown names give PAR_BAD.
    function automatic logic [2:0] parity_code(input string mode);
        if (mode == "NONE")  return PAR_NONE;
        if (mode == "ODD")   return PAR_ODD;
        if (mode == "EVEN")  return PAR_EVEN;
        if (mode == "MARK")  return PAR_MARK;
        if (mode == "SPACE") return PAR_SPACE;
        return PAR_BAD;
    endfunction

    // Parity bit for a payload zero-extended to 9 bits (extension does not change parity).
    function automatic logic parity_bit(input logic [2:0] mode, input logic [8:0] data);
        case (mode)
            PAR_ODD:  return ~^data;
            PAR_EVEN: return ^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy level; caller never writes when full without a pop,
// nor pops when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_c,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic [PTR_W:0]   level_d;
    logic             full_q;

    always_comb begin
        level_d = level_q;
        if (wr_en_i && !rd_en_i) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en_i && rd_en_i) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally; full/empty are derived from the level alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == (PTR_W + 1)'(DEPTH));
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign level_o   = level_q;
    assign full_o    = full_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, integer baud divider and configurable frame format.
// tx is registered from the current state, so every line transition lags the FSM by one clock.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 5208,
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "ODD",
    parameter int    STOP_BIT     = 1,
    parameter int    FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_rdy,
    output logic                        tx_ack,
    input  logic                        tx_en,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        fifo_full,
    output logic                        busy,
    output logic                        tx
);

    localparam logic [2:0] PAR_MODE =
        (PARITY == "NONE")  ? PAR_NONE  :
        (PARITY == "ODD")   ? PAR_ODD   :
        (PARITY == "EVEN")  ? PAR_EVEN  :
        (PARITY == "MARK")  ? PAR_MARK  :
        (PARITY == "SPACE") ? PAR_SPACE : PAR_BAD;

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned       BIT_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BIT - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PAR_MODE == PAR_BAD ||
        (STOP_BIT != 1 && STOP_BIT != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: parameter out of legal range");
    end

    logic [2:0]           state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ack_q, busy_q, busy_d;
    logic                 pop_c, wr_c, start_c, tick_c, empty_c;
    logic [DATA_BITS-1:0] fifo_rd_data;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_c),
        .wr_data_i (tx_data),
        .rd_en_i   (pop_c),
        .rd_data_c (fifo_rd_data),
        .level_o   (fifo_level),
        .full_o    (fifo_full)
    );

    // A full FIFO still accepts when a word leaves in the same cycle.
    assign wr_c    = tx_rdy && !ack_q && (!fifo_full || pop_c);
    assign empty_c = (fifo_level == '0);
    assign start_c = tx_en && !empty_c;
    assign tick_c  = (baud_q == '0);
    assign busy_d  = (state_q != ST_IDLE) || (state_d != ST_IDLE) || !empty_c || wr_c;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        pop_c   = 1'b0;
        if (state_q != ST_IDLE) begin
            baud_d = tick_c ? BAUD_MAX : baud_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_MAX;
                bit_d  = '0;
                if (start_c) begin
                    pop_c   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (tick_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (tick_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PAR;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                tx_d = par_q;
                if (tick_c) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                // bit_q counts stop bits here; back-to-back frames skip IDLE.
                if (tick_c) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (start_c) begin
                            pop_c   = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop_c) begin
            shift_d = fifo_rd_data;
            par_d   = parity_bit(PAR_MODE, 9'(fifo_rd_data));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_MAX;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ack_q   <= wr_c;
            busy_q  <= busy_d;
        end
    end

    assign tx_ack = ack_q;
    assign busy   = busy_q;
    assign tx     = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes expected line frames, a line monitor
// decodes every frame on tx cycle by cycle and compares.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] tx_data;
    logic       tx_rdy;
    logic       tx_en;
    int         sel;

    logic [4:0] rdy_w, ack_w, full_w, busy_w, tx_w;
    logic [2:0] lvl_w [5];
    logic       tx_mon, ack_mon;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     frames_done = 0;
    frame_t exp_q[$];
    int     starts[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdy_w   = tx_rdy ? 5'(1 << sel) : 5'b0;
    assign tx_mon  = tx_w[sel];
    assign ack_mon = ack_w[sel];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY("ODD"), .STOP_BIT(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_rdy(rdy_w[0]), .tx_ack(ack_w[0]),
        .tx_en(tx_en), .fifo_level(lvl_w[0]), .fifo_full(full_w[0]), .busy(busy_w[0]), .tx(tx_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY("NONE"), .STOP_BIT(2), .FIFO_DEPTH(4)) u_none (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_rdy(rdy_w[1]), .tx_ack(ack_w[1]),
        .tx_en(tx_en), .fifo_level(lvl_w[1]), .fifo_full(full_w[1]), .busy(busy_w[1]), .tx(tx_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY("EVEN"), .STOP_BIT(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_rdy(rdy_w[2]), .tx_ack(ack_w[2]),
        .tx_en(tx_en), .fifo_level(lvl_w[2]), .fifo_full(full_w[2]), .busy(busy_w[2]), .tx(tx_w[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY("MARK"), .STOP_BIT(1), .FIFO_DEPTH(4)) u_mark (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_rdy(rdy_w[3]), .tx_ack(ack_w[3]),
        .tx_en(tx_en), .fifo_level(lvl_w[3]), .fifo_full(full_w[3]), .busy(busy_w[3]), .tx(tx_w[3]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY("SPACE"), .STOP_BIT(1), .FIFO_DEPTH(4)) u_space (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_rdy(rdy_w[4]), .tx_ack(ack_w[4]),
        .tx_en(tx_en), .fifo_level(lvl_w[4]), .fifo_full(full_w[4]), .busy(busy_w[4]), .tx(tx_w[4]));

    // Line frame: start 0, data LSB first, optional hand-supplied parity bit, stop 1s.
    function automatic frame_t mk(input logic [8:0] d, input int nd, input int has_par,
                                  input logic p, input int ns);
        frame_t f;
        int     idx;
        f.bits = '0;
        for (int i = 0; i < nd; i++) f.bits[1 + i] = d[i];
        idx = 1 + nd;
        if (has_par != 0) begin
            f.bits[idx] = p;
            idx++;
        end
        for (int s = 0; s < ns; s++) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.n = idx;
        return f;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic send(input logic [8:0] d, output int acc_cyc);
        int n;
        tx_data = d;
        tx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_mon && n < 50);
        if (!ack_mon) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: no ack for data 0x%0h", d);
        end
        acc_cyc = cyc;
        tx_rdy  = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy_w[sel]) && n < 1000);
        if (exp_q.size() != 0 || busy_w[sel]) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout: %0d frames outstanding, busy %0b", exp_q.size(), busy_w[sel]);
        end
        done_cyc = cyc;
    endtask

    task automatic wait_start(input int n0, output int s);
        int n;
        n = 0;
        while (starts.size() <= n0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (starts.size() <= n0) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: no frame start seen");
            s = cyc;
        end else begin
            s = starts[n0];
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Line monitor: every falling edge from idle is a frame; each bit must hold for CPB clocks.
    initial begin : monitor
        logic        prev, stable, aborted, has_exp;
        logic [15:0] got;
        frame_t      e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !tx_mon) begin
                starts.push_back(cyc);
                has_exp = (exp_q.size() != 0);
                if (has_exp) begin
                    e = exp_q.pop_front();
                end else begin
                    e.bits = '0;
                    e.n    = 11;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d on dut %0d", cyc, sel);
                end
                got = '0;
                stable = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < e.n && !aborted; b++) begin
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        else if (c == 0) got[b] = tx_mon;
                        else if (tx_mon !== got[b]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    if (has_exp) begin
                        checks++;
                        if (got !== e.bits || !stable) begin
                            errors++;
                            $display("FAIL frame: got bits 0x%04h stable %0b expected 0x%04h (%0d bits)",
                                     got, stable, e.bits, e.n);
                        end
                    end
                    frames_done++;
                    prev = tx_mon;
                end
            end else begin
                prev = tx_mon;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int a1, a2, s, d, n0, acks, fd, e0;
        logic [2:0] par4 [3];
        par4[0] = 1'b1;  // EVEN, 0x07 has three ones
        par4[1] = 1'b1;  // MARK
        par4[2] = 1'b0;  // SPACE
        rst_n = 1'b0; tx_rdy = 1'b0; tx_data = '0; tx_en = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx_w[0]), 1);
        chk("reset_ack", int'(ack_w[0]), 0);
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_level", int'(lvl_w[0]), 0);
        chk("reset_full", int'(full_w[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two back-to-back frames, odd parity.
        tx_en = 1'b1;
        n0 = starts.size();
        send(9'h01, a1);
        exp_q.push_back(mk(9'h01, 8, 1, 1'b0, 1));
        send(9'h03, a2);
        exp_q.push_back(mk(9'h03, 8, 1, 1'b1, 1));
        wait_done(d);
        chk("start_latency", starts[n0] - a1, 2);
        chk("frame_period_no_gap", starts[n0 + 1] - starts[n0], 44);
        chk("frame1_end", d - starts[n0 + 1], 44);

        // Fill the FIFO with transmission disabled.
        tx_en = 1'b0;
        n0 = starts.size();
        tx_data = 9'h10;
        tx_rdy = 1'b1;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack_mon) begin
                acks++;
                tx_data = tx_data + 9'd1;
            end
        end
        chk("fill_acks", acks, 4);
        chk("fill_full", int'(full_w[0]), 1);
        chk("fill_level", int'(lvl_w[0]), 4);
        chk("fill_tx_idle", int'(tx_w[0]), 1);
        chk("fill_no_frames", starts.size(), n0);
        exp_q.push_back(mk(9'h10, 8, 1, 1'b0, 1));
        exp_q.push_back(mk(9'h11, 8, 1, 1'b1, 1));
        exp_q.push_back(mk(9'h12, 8, 1, 1'b1, 1));
        exp_q.push_back(mk(9'h13, 8, 1, 1'b0, 1));
        exp_q.push_back(mk(9'h14, 8, 1, 1'b1, 1));
        tx_en = 1'b1;
        @(negedge clk);
        chk("pop_cycle_ack", int'(ack_mon), 1);
        chk("pop_cycle_level", int'(lvl_w[0]), 4);
        tx_rdy = 1'b0;
        wait_done(d);

        // 7 data bits, no parity, two stop bits.
        sel = 1;
        n0 = starts.size();
        send(9'h55, a1);
        exp_q.push_back(mk(9'h55, 7, 0, 1'b0, 2));
        wait_done(d);
        chk("none_frame_len", d - starts[n0], 40);

        // EVEN / MARK / SPACE parity on 0x07.
        for (int k = 0; k < 3; k++) begin
            sel = 2 + k;
            n0 = starts.size();
            send(9'h07, a1);
            exp_q.push_back(mk(9'h07, 8, 1, par4[k][0], 1));
            wait_done(d);
            chk("parity_mode_frame_len", d - starts[n0], 44);
        end

        // Reset in the middle of a frame with two words queued.
        sel = 0;
        n0 = starts.size();
        send(9'hA5, a1);
        exp_q.push_back(mk(9'hA5, 8, 1, 1'b1, 1));
        send(9'h11, a1);
        send(9'h22, a1);
        wait_start(n0, s);
        wait_cyc(s + 17);
        chk("pre_reset_level", int'(lvl_w[0]), 2);
        chk("pre_reset_bit3", int'(tx_w[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", int'(tx_w[0]), 1);
        chk("abort_level", int'(lvl_w[0]), 0);
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_full", int'(full_w[0]), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(9'h3C, a1);
        exp_q.push_back(mk(9'h3C, 8, 1, 1'b1, 1));
        wait_done(d);

        // tx_en dropped mid-frame: current frame completes, queued word waits.
        n0 = starts.size();
        send(9'h5A, a1);
        exp_q.push_back(mk(9'h5A, 8, 1, 1'b1, 1));
        send(9'h0F, a2);
        exp_q.push_back(mk(9'h0F, 8, 1, 1'b1, 1));
        wait_start(n0, s);
        wait_cyc(s + 10);
        tx_en = 1'b0;
        fd = frames_done;
        wait_cyc(s + 44);
        repeat (8) @(negedge clk);
        chk("en_low_frame_done", frames_done, fd + 1);
        chk("en_low_no_start", starts.size(), n0 + 1);
        chk("en_low_tx_idle", int'(tx_w[0]), 1);
        chk("en_low_level", int'(lvl_w[0]), 1);
        tx_en = 1'b1;
        e0 = cyc;
        wait_start(n0 + 1, s);
        chk("en_high_start", s - e0, 2);
        wait_done(d);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
